// File: rtl/nano_pkg.sv
// Shared Nano core definitions: I/O opcodes and the default datapath width.
// Imported by the controller and by the I/O peripheral.
package nano_pkg;

    localparam int NANO_DW = 8;

    typedef enum logic [3:0] {
        opINPUT  = 4'hE,
        opOUTPUT = 4'hF
    } nano_io_op_t;

endpackage

// File: rtl/nano_io_fifo.sv
// Show-ahead output FIFO for the Nano I/O port.
// Tracks occupancy, full status and a sticky overflow flag for dropped pushes.
module nano_io_fifo
    import nano_pkg::*;
#(
    parameter int DW    = NANO_DW,
    parameter int DEPTH = 4,
    parameter int AW    = 2
)
(
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop_ready,
    input  logic          flag_clr,
    output logic [DW-1:0] head,
    output logic          valid,
    output logic [AW:0]   count,
    output logic          full,
    output logic          overflow
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          pop;
    logic          push_ok;
    logic          drop;

    assign valid   = (count != '0);
    assign full    = (count == FULL_COUNT);
    assign pop     = valid & pop_ready;
    assign push_ok = push & (~full | pop);
    assign drop    = push & ~push_ok;
    assign head    = mem[rd_ptr];

    // Storage needs no reset; only the pointers decide what is visible.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // A dropped push in the same cycle as a clear leaves the flag set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (flag_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: rtl/nano_io_port.sv
// Nano core I/O peripheral: output FIFO toward the board consumer and a
// single-byte input holding register fed by the board producer.
module nano_io_port
    import nano_pkg::*;
#(
    parameter int DW    = NANO_DW,
    parameter int DEPTH = 4,
    parameter int AW    = 2
)
(
    input  logic          clk,
    input  logic          rst,
    input  logic          ld_output,
    input  logic [DW-1:0] out_value,
    output logic [DW-1:0] ext_out_data,
    output logic          ext_out_valid,
    input  logic          ext_out_ready,
    output logic [AW:0]   out_count,
    output logic          out_full,
    output logic          out_overflow,
    input  logic          rd_input,
    output logic [DW-1:0] in_value,
    output logic          in_avail,
    input  logic [DW-1:0] ext_in_data,
    input  logic          ext_in_valid,
    output logic          ext_in_ready,
    output logic          in_underflow,
    input  logic          flag_clr
);

    logic accept;
    logic underflow_set;

    nano_io_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (ld_output),
        .push_data (out_value),
        .pop_ready (ext_out_ready),
        .flag_clr  (flag_clr),
        .head      (ext_out_data),
        .valid     (ext_out_valid),
        .count     (out_count),
        .full      (out_full),
        .overflow  (out_overflow)
    );

    // Ready depends only on the holding register, never on rd_input.
    assign ext_in_ready  = ~in_avail;
    assign accept        = ext_in_valid & ext_in_ready;
    assign underflow_set = rd_input & ~in_avail;

    // A read drops in_avail but keeps the byte visible on in_value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_value <= '0;
            in_avail <= 1'b0;
        end else if (accept) begin
            in_value <= ext_in_data;
            in_avail <= 1'b1;
        end else if (rd_input) begin
            in_avail <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_underflow <= 1'b0;
        end else if (underflow_set) begin
            in_underflow <= 1'b1;
        end else if (flag_clr) begin
            in_underflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_nano_io_port.sv
// Self-checking bench for nano_io_port: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_nano_io_port;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ld_output = 1'b0;
    logic [DW-1:0] out_value = '0;
    logic [DW-1:0] ext_out_data;
    logic          ext_out_valid;
    logic          ext_out_ready = 1'b0;
    logic [AW:0]   out_count;
    logic          out_full;
    logic          out_overflow;
    logic          rd_input = 1'b0;
    logic [DW-1:0] in_value;
    logic          in_avail;
    logic [DW-1:0] ext_in_data = '0;
    logic          ext_in_valid = 1'b0;
    logic          ext_in_ready;
    logic          in_underflow;
    logic          flag_clr = 1'b0;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] modelQ[$];
    logic          modelOvf;
    logic          modelAvail;
    logic [DW-1:0] modelInValue;
    logic          modelUf;

    always #5 clk = ~clk;

    nano_io_port #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk           (clk),
        .rst           (rst),
        .ld_output     (ld_output),
        .out_value     (out_value),
        .ext_out_data  (ext_out_data),
        .ext_out_valid (ext_out_valid),
        .ext_out_ready (ext_out_ready),
        .out_count     (out_count),
        .out_full      (out_full),
        .out_overflow  (out_overflow),
        .rd_input      (rd_input),
        .in_value      (in_value),
        .in_avail      (in_avail),
        .ext_in_data   (ext_in_data),
        .ext_in_valid  (ext_in_valid),
        .ext_in_ready  (ext_in_ready),
        .in_underflow  (in_underflow),
        .flag_clr      (flag_clr)
    );

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, ":valid"}, 32'(ext_out_valid), 32'(modelQ.size() != 0));
        checkVal({tag, ":count"}, 32'(out_count), 32'(modelQ.size()));
        checkVal({tag, ":full"}, 32'(out_full), 32'(modelQ.size() == DEPTH));
        checkVal({tag, ":ovf"}, 32'(out_overflow), 32'(modelOvf));
        if (modelQ.size() != 0) begin
            checkVal({tag, ":head"}, 32'(ext_out_data), 32'(modelQ[0]));
        end
        checkVal({tag, ":avail"}, 32'(in_avail), 32'(modelAvail));
        checkVal({tag, ":inready"}, 32'(ext_in_ready), 32'(!modelAvail));
        checkVal({tag, ":invalue"}, 32'(in_value), 32'(modelInValue));
        checkVal({tag, ":uf"}, 32'(in_underflow), 32'(modelUf));
    endtask

    task automatic modelReset();
        modelQ.delete();
        modelOvf     = 1'b0;
        modelAvail   = 1'b0;
        modelInValue = '0;
        modelUf      = 1'b0;
    endtask

    // Output side: pop the head if a consumer takes it, then enqueue if there is room.
    task automatic modelStep(input logic ld, input logic [DW-1:0] val, input logic ordy,
                             input logic rd, input logic ivld, input logic [DW-1:0] idata,
                             input logic clr);
        bit doPop;
        bit canPush;
        bit doAccept;
        bit ufSet;
        doPop   = (modelQ.size() != 0) && ordy;
        canPush = ld && ((modelQ.size() < DEPTH) || doPop);
        if (doPop) void'(modelQ.pop_front());
        if (canPush) modelQ.push_back(val);
        if (ld && !canPush) modelOvf = 1'b1;
        else if (clr) modelOvf = 1'b0;
        doAccept = ivld && !modelAvail;
        ufSet    = rd && !modelAvail;
        if (doAccept) begin
            modelInValue = idata;
            modelAvail   = 1'b1;
        end else if (rd) begin
            modelAvail = 1'b0;
        end
        if (ufSet) modelUf = 1'b1;
        else if (clr) modelUf = 1'b0;
    endtask

    task automatic applyStimulus(input logic ld, input logic [DW-1:0] val, input logic ordy,
                                 input logic rd, input logic ivld, input logic [DW-1:0] idata,
                                 input logic clr, input string tag);
        ld_output     = ld;
        out_value     = val;
        ext_out_ready = ordy;
        rd_input      = rd;
        ext_in_valid  = ivld;
        ext_in_data   = idata;
        flag_clr      = clr;
        modelStep(ld, val, ordy, rd, ivld, idata, clr);
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) applyStimulus(0, 8'h00, 0, 0, 0, 8'h00, 0, tag);
    endtask

    initial begin
        logic [31:0] r;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset");
        rst = 1'b1;
        idle(2, "idle");

        // Three pushes held back, then drained in order
        applyStimulus(1, 8'h11, 0, 0, 0, 8'h00, 0, "push11");
        applyStimulus(1, 8'h22, 0, 0, 0, 8'h00, 0, "push22");
        applyStimulus(1, 8'h33, 0, 0, 0, 8'h00, 0, "push33");
        checkVal("three_count", 32'(out_count), 32'd3);
        for (int i = 0; i < 3; i++) applyStimulus(0, 8'h00, 1, 0, 0, 8'h00, 0, "drain3");
        checkVal("three_empty", 32'(ext_out_valid), 32'd0);

        // Overflow on the fifth push, then drain and clear
        for (int i = 0; i < 5; i++) applyStimulus(1, 8'hA0 + 8'(i), 0, 0, 0, 8'h00, 0, "pushA");
        checkVal("ovf_full", 32'(out_full), 32'd1);
        checkVal("ovf_flag", 32'(out_overflow), 32'd1);
        checkVal("ovf_head", 32'(ext_out_data), 32'hA0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 8'h00, 1, 0, 0, 8'h00, 0, "drainA");
        applyStimulus(0, 8'h00, 0, 0, 0, 8'h00, 1, "clrovf");
        checkVal("ovf_cleared", 32'(out_overflow), 32'd0);

        // Full FIFO with simultaneous push and pop
        for (int i = 0; i < 4; i++) applyStimulus(1, 8'h61 + 8'(i), 0, 0, 0, 8'h00, 0, "fill");
        applyStimulus(1, 8'h55, 1, 0, 0, 8'h00, 0, "pushpop");
        checkVal("pp_count", 32'(out_count), 32'd4);
        checkVal("pp_ovf", 32'(out_overflow), 32'd0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 8'h00, 1, 0, 0, 8'h00, 0, "drainpp");
        checkVal("pp_last", 32'(ext_out_data), 32'h55);
        applyStimulus(0, 8'h00, 1, 0, 0, 8'h00, 0, "drainpp");

        // Input holding register back-pressure
        applyStimulus(0, 8'h00, 0, 0, 1, 8'h7E, 0, "in7E");
        checkVal("in_ready_low", 32'(ext_in_ready), 32'd0);
        applyStimulus(0, 8'h00, 0, 0, 1, 8'h01, 0, "in01blocked");
        applyStimulus(0, 8'h00, 0, 1, 1, 8'h01, 0, "rd7E");
        checkVal("rd_value", 32'(in_value), 32'h7E);
        applyStimulus(0, 8'h00, 0, 0, 1, 8'h01, 0, "in01");
        checkVal("in01_value", 32'(in_value), 32'h01);
        applyStimulus(0, 8'h00, 0, 1, 0, 8'h00, 0, "rd01");

        // Underflow read coinciding with an accept
        applyStimulus(0, 8'h00, 0, 1, 1, 8'h42, 0, "uf42");
        checkVal("uf_flag", 32'(in_underflow), 32'd1);
        checkVal("uf_value", 32'(in_value), 32'h42);
        applyStimulus(0, 8'h00, 0, 0, 0, 8'h00, 1, "clruf");

        // Asynchronous reset with data pending on both sides
        applyStimulus(1, 8'h99, 0, 0, 0, 8'h00, 0, "prerst");
        applyStimulus(1, 8'h9A, 0, 0, 0, 8'h00, 1, "prerst");
        #2;
        rst = 1'b0;
        #1;
        modelReset();
        checkOutput("midreset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(1, "postreset");

        // Random traffic on both sides
        for (int i = 0; i < 400; i++) begin
            r = $urandom;
            applyStimulus(r[0], r[15:8], r[1], r[2] & r[3], r[4], r[23:16],
                          r[5] & r[6] & r[7], "rand");
        end
        idle(6, "final");
        for (int i = 0; i < 6; i++) applyStimulus(0, 8'h00, 1, 1, 0, 8'h00, 0, "flush");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
